// File: rtl/hazard_scoreboard_pkg.sv
// ---------------------------------------------------------------------------
// hazard_scoreboard_pkg
// Shared pipeline definitions for the issue-stage interlock: register file
// geometry, result-latency encodings and the register address type.
// No ports (package).
// ---------------------------------------------------------------------------
package hazard_scoreboard_pkg;

   localparam int NREG = 8;
   localparam int AW   = 3;
   localparam int LW   = 2;

   // Cycles from issue until the result reaches the bypass point.
   localparam logic [LW-1:0] LAT_ALU  = 2'd0;
   localparam logic [LW-1:0] LAT_LOAD = 2'd2;
   localparam logic [LW-1:0] LAT_MUL  = 2'd3;

   typedef logic [AW-1:0] reg_addr_t;

endpackage : hazard_scoreboard_pkg

// File: rtl/hazard_scoreboard_reg_countdown.sv
// ---------------------------------------------------------------------------
// reg_countdown
// One per-register result countdown. Counts the cycles remaining until the
// register's in-flight result is available to a consumer.
// Ports:
//   clk        in  clock
//   rst_n      in  synchronous active-low reset
//   i_flush    in  clear the counter (squash in-flight result)
//   i_load     in  load i_load_val (new producer accepted)
//   i_load_val in  LW  latency of the new producer
//   o_cnt      out LW  current countdown value
// ---------------------------------------------------------------------------
module reg_countdown
   import hazard_scoreboard_pkg::*;
#(
   parameter int CW = 2
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          i_flush,
   input  logic          i_load,
   input  logic [CW-1:0] i_load_val,
   output logic [CW-1:0] o_cnt
);

   logic [CW-1:0] r_cnt;

   // Countdown register: flush beats load, load beats decrement.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_cnt <= {CW{1'b0}};
      end else if (i_flush) begin
         r_cnt <= {CW{1'b0}};
      end else if (i_load) begin
         r_cnt <= i_load_val;
      end else if (r_cnt != {CW{1'b0}}) begin
         r_cnt <= r_cnt - CW'(1);
      end else begin
         r_cnt <= r_cnt;
      end
   end

   assign o_cnt = r_cnt;

endmodule : reg_countdown

// File: rtl/hazard_scoreboard.sv
// ---------------------------------------------------------------------------
// hazard_scoreboard
// Issue-stage interlock. Tracks the remaining result latency of every
// destination register and stalls an instruction whose sources (RAW) or
// destination (WAW) collide with a result not yet available.
// Ports:
//   clk            in  clock
//   rst_n          in  synchronous active-low reset
//   issue_valid    in  decode presents an instruction
//   issue_rs1/rs2  in  AW  source registers
//   issue_use_rs1/2 in     instruction reads the source
//   issue_rd       in  AW  destination register
//   issue_regwrite in      instruction writes rd
//   issue_lat      in  LW  result latency (0 = available next issue)
//   flush          in      squash all in-flight state
//   stall          out     hold decode this cycle (combinational)
//   pending        out NREG per-register "result outstanding"
//   stall_count    out SW  saturating count of stalled cycles
// ---------------------------------------------------------------------------
module hazard_scoreboard
   import hazard_scoreboard_pkg::*;
#(
   parameter int NREG = 8,
   parameter int AW   = 3,
   parameter int LW   = 2,
   parameter int SW   = 16
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            issue_valid,
   input  logic [AW-1:0]   issue_rs1,
   input  logic [AW-1:0]   issue_rs2,
   input  logic            issue_use_rs1,
   input  logic            issue_use_rs2,
   input  logic [AW-1:0]   issue_rd,
   input  logic            issue_regwrite,
   input  logic [LW-1:0]   issue_lat,
   input  logic            flush,
   output logic            stall,
   output logic [NREG-1:0] pending,
   output logic [SW-1:0]   stall_count
);

   logic [LW-1:0] w_cnt [NREG];
   logic          w_raw;
   logic          w_waw;
   logic          w_stall;
   logic          w_accept;
   logic [SW-1:0] r_stall_count;

   // Register 0 is hard-wired zero, so it never carries a result.
   assign w_cnt[0] = {LW{1'b0}};

   for (genvar g = 1; g < NREG; g++) begin : g_cnt
      logic w_load;
      assign w_load = w_accept && issue_regwrite && (issue_rd == AW'(g));

      reg_countdown #(
         .CW (LW)
      ) u_cnt (
         .clk        (clk),
         .rst_n      (rst_n),
         .i_flush    (flush),
         .i_load     (w_load),
         .i_load_val (issue_lat),
         .o_cnt      (w_cnt[g])
      );
   end

   // Hazard detection. cnt[0] is constant 0, which makes source/destination 0
   // hazard-free without extra compares. WAW only fires when the new result
   // would land before the outstanding one (out-of-order completion).
   always_comb begin
      w_raw = 1'b0;
      w_waw = 1'b0;
      if (issue_use_rs1 && (w_cnt[issue_rs1] != {LW{1'b0}})) begin
         w_raw = 1'b1;
      end else if (issue_use_rs2 && (w_cnt[issue_rs2] != {LW{1'b0}})) begin
         w_raw = 1'b1;
      end else begin
         w_raw = 1'b0;
      end
      if (issue_regwrite && (issue_rd != {AW{1'b0}}) && (issue_lat < w_cnt[issue_rd])) begin
         w_waw = 1'b1;
      end else begin
         w_waw = 1'b0;
      end
   end

   assign w_stall  = issue_valid && !flush && (w_raw || w_waw);
   assign w_accept = issue_valid && !flush && !w_stall;

   // Pending vector derived straight from the counter registers.
   always_comb begin
      pending = {NREG{1'b0}};
      for (int r = 0; r < NREG; r++) begin
         pending[r] = (w_cnt[r] != {LW{1'b0}});
      end
   end

   // Saturating stall counter; survives flush, cleared only by reset.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_stall_count <= {SW{1'b0}};
      end else if (w_stall && (r_stall_count != {SW{1'b1}})) begin
         r_stall_count <= r_stall_count + SW'(1);
      end else begin
         r_stall_count <= r_stall_count;
      end
   end

   assign stall       = w_stall;
   assign stall_count = r_stall_count;

endmodule : hazard_scoreboard

// File: tb/tb_hazard_scoreboard.sv
module tb_hazard_scoreboard;
   import hazard_scoreboard_pkg::*;

   localparam int TNREG = 8;
   localparam int TAW   = 3;
   localparam int TLW   = 2;
   localparam int TSW   = 4;
   localparam int SCMAX = 15;

   logic             clk = 1'b0;
   logic             rst_n;
   logic             issue_valid;
   logic [TAW-1:0]   issue_rs1, issue_rs2, issue_rd;
   logic             issue_use_rs1, issue_use_rs2, issue_regwrite;
   logic [TLW-1:0]   issue_lat;
   logic             flush;
   logic             stall;
   logic [TNREG-1:0] pending;
   logic [TSW-1:0]   stall_count;

   always #5 clk = ~clk;

   hazard_scoreboard #(.NREG(TNREG), .AW(TAW), .LW(TLW), .SW(TSW)) dut (
      .clk(clk), .rst_n(rst_n), .issue_valid(issue_valid),
      .issue_rs1(issue_rs1), .issue_rs2(issue_rs2),
      .issue_use_rs1(issue_use_rs1), .issue_use_rs2(issue_use_rs2),
      .issue_rd(issue_rd), .issue_regwrite(issue_regwrite),
      .issue_lat(issue_lat), .flush(flush), .stall(stall),
      .pending(pending), .stall_count(stall_count));

   // Reference model: absolute cycle at which each register's result is ready.
   int ready_at [TNREG];
   int now;
   int model_sc;
   int checks;
   int errors;
   logic last_stall;

   function automatic int remaining(input int r);
      if (r == 0) return 0;
      return (ready_at[r] > now) ? ready_at[r] - now : 0;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // One clock cycle: drive inputs, compare outputs against the model, advance.
   task automatic cyc(input logic v, input int rs1, input int rs2, input logic u1,
                      input logic u2, input int rd, input logic rw, input int lat,
                      input logic fl, input logic rst, input logic do_chk);
      logic exp_stall, hz;
      logic [TNREG-1:0] exp_pend;
      issue_valid = v; issue_rs1 = TAW'(rs1); issue_rs2 = TAW'(rs2);
      issue_use_rs1 = u1; issue_use_rs2 = u2; issue_rd = TAW'(rd);
      issue_regwrite = rw; issue_lat = TLW'(lat); flush = fl; rst_n = rst;
      #2;
      hz = (u1 && remaining(rs1) > 0) || (u2 && remaining(rs2) > 0) ||
           (rw && rd != 0 && lat < remaining(rd));
      exp_stall = v && !fl && hz;
      for (int r = 0; r < TNREG; r++) exp_pend[r] = (remaining(r) > 0);
      last_stall = stall;
      if (do_chk) begin
         chk("stall", 32'(stall), 32'(exp_stall));
         chk("pending", 32'(pending), 32'(exp_pend));
         chk("stall_count", 32'(stall_count), 32'(model_sc));
      end
      @(posedge clk);
      if (!rst) begin
         for (int r = 0; r < TNREG; r++) ready_at[r] = 0;
         model_sc = 0;
      end else begin
         if (exp_stall && model_sc < SCMAX) model_sc++;
         if (fl) begin
            for (int r = 0; r < TNREG; r++) ready_at[r] = 0;
         end else if (v && !exp_stall && rw && rd != 0) begin
            ready_at[rd] = now + 1 + lat;
         end
      end
      now++;
      #1;
   endtask

   task automatic idle();
      cyc(1'b0, 0, 0, 1'b0, 1'b0, 0, 1'b0, 0, 1'b0, 1'b1, 1'b1);
   endtask

   initial begin
      int n, sc0;
      checks = 0; errors = 0; now = 0; model_sc = 0;
      for (int r = 0; r < TNREG; r++) ready_at[r] = 0;
      @(posedge clk); #1;

      // Reset for 2 cycles with issue_valid high (model state unknown before).
      cyc(1'b1, 1, 2, 1'b1, 1'b1, 3, 1'b1, 3, 1'b0, 1'b0, 1'b0);
      cyc(1'b1, 1, 2, 1'b1, 1'b1, 3, 1'b1, 3, 1'b0, 1'b0, 1'b0);
      idle();
      chk("rst_stall", 32'(stall), 32'd0);
      chk("rst_pending", 32'(pending), 32'd0);
      chk("rst_sc", 32'(stall_count), 32'd0);

      // Load-use: exactly LAT_LOAD stall cycles.
      cyc(1'b1, 0, 0, 1'b0, 1'b0, 3, 1'b1, int'(LAT_LOAD), 1'b0, 1'b1, 1'b1);
      n = 0;
      for (int i = 0; i < 10; i++) begin
         cyc(1'b1, 3, 0, 1'b1, 1'b0, 1, 1'b1, 0, 1'b0, 1'b1, 1'b1);
         if (!last_stall) break;
         n++;
      end
      chk("loaduse_len", 32'(n), 32'd2);
      chk("loaduse_sc", 32'(stall_count), 32'd2);

      // Register 0 is never recorded and never a hazard.
      cyc(1'b1, 0, 0, 1'b0, 1'b0, 0, 1'b1, int'(LAT_MUL), 1'b0, 1'b1, 1'b1);
      cyc(1'b1, 0, 0, 1'b1, 1'b1, 1, 1'b1, 0, 1'b0, 1'b1, 1'b1);
      chk("r0_stall", 32'(last_stall), 32'd0);
      chk("r0_pending", 32'(pending & 8'h01), 32'd0);
      idle();

      // WAW: younger short-latency write waits for the older long one.
      cyc(1'b1, 0, 0, 1'b0, 1'b0, 5, 1'b1, int'(LAT_MUL), 1'b0, 1'b1, 1'b1);
      n = 0;
      for (int i = 0; i < 10; i++) begin
         cyc(1'b1, 0, 0, 1'b0, 1'b0, 5, 1'b1, int'(LAT_ALU), 1'b0, 1'b1, 1'b1);
         if (!last_stall) break;
         n++;
      end
      chk("waw_len", 32'(n), 32'd3);
      cyc(1'b1, 0, 0, 1'b0, 1'b0, 5, 1'b1, int'(LAT_MUL), 1'b0, 1'b1, 1'b1);
      idle();
      cyc(1'b1, 0, 0, 1'b0, 1'b0, 5, 1'b1, int'(LAT_LOAD), 1'b0, 1'b1, 1'b1);
      chk("waw_equal_ok", 32'(last_stall), 32'd0);
      for (int i = 0; i < 3; i++) idle();

      // Flush while a consumer is stalled.
      cyc(1'b1, 0, 0, 1'b0, 1'b0, 2, 1'b1, 3, 1'b0, 1'b1, 1'b1);
      cyc(1'b1, 0, 0, 1'b0, 1'b0, 4, 1'b1, 3, 1'b0, 1'b1, 1'b1);
      chk("flush_pend_pre", 32'(pending), 32'h14);
      cyc(1'b1, 2, 0, 1'b1, 1'b0, 6, 1'b1, 1, 1'b0, 1'b1, 1'b1);
      chk("flush_stalled", 32'(last_stall), 32'd1);
      sc0 = int'(stall_count);
      cyc(1'b1, 2, 0, 1'b1, 1'b0, 6, 1'b1, 1, 1'b1, 1'b1, 1'b1);
      chk("flush_nostall", 32'(last_stall), 32'd0);
      chk("flush_pend_post", 32'(pending), 32'd0);
      chk("flush_sc_kept", 32'(stall_count), 32'(sc0));

      // Saturation: repeated producer/consumer load-use pairs.
      for (int i = 0; i < 8; i++) begin
         cyc(1'b1, 0, 0, 1'b0, 1'b0, 6, 1'b1, 3, 1'b0, 1'b1, 1'b1);
         for (int k = 0; k < 4; k++) cyc(1'b1, 6, 6, 1'b1, 1'b1, 7, 1'b0, 0, 1'b0, 1'b1, 1'b1);
      end
      chk("sat_sc", 32'(stall_count), 32'd15);

      // Mid-operation reset discards in-flight results.
      cyc(1'b1, 0, 0, 1'b0, 1'b0, 1, 1'b1, 3, 1'b0, 1'b1, 1'b1);
      cyc(1'b1, 1, 0, 1'b1, 1'b0, 2, 1'b1, 0, 1'b0, 1'b0, 1'b1);
      chk("midrst_pend", 32'(pending), 32'd0);
      chk("midrst_sc", 32'(stall_count), 32'd0);

      // Randomized traffic against the model.
      for (int i = 0; i < 3000; i++) begin
         cyc(($urandom_range(0, 9) < 8), int'($urandom_range(0, 7)), int'($urandom_range(0, 7)),
             1'($urandom), 1'($urandom), int'($urandom_range(0, 7)), ($urandom_range(0, 3) != 0),
             int'($urandom_range(0, 3)), ($urandom_range(0, 39) == 0),
             ($urandom_range(0, 499) != 0), 1'b1);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule : tb_hazard_scoreboard
